// File: rtl/multicycle_ctrl_if.sv
// Control-path bundle between the multicycle FSM (master) and the datapath (slave).
// opcode/zero/mem_ready flow into the controller; every other signal flows out of it.
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_source;
  logic [3:0]  state;
  logic        illegal_op;
  logic [15:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: R-type, lw, sw, beq and j, with memory
// wait states, an illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ILLEGAL  = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      r_state;
  state_t      w_next;
  ctrl_t       r_ctrl;
  logic [15:0] r_instr_count;
  logic        w_retire;
  logic        w_fetch_done;

  // Moore outputs per state; FETCH's ir_write/pc_write are added combinationally below.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE:   c.alu_src_b = 2'b11;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      ILLEGAL:  c.illegal_op = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      FETCH:    if (bus.mem_ready) w_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_next = EXEC;
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          default:      w_next = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        if (bus.opcode == OP_LW)      w_next = MEM_RD;
        else if (bus.opcode == OP_SW) w_next = MEM_WR;
        else                          w_next = ILLEGAL;
      end
      MEM_RD:   if (bus.mem_ready) w_next = MEM_WB;
      MEM_WB: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      MEM_WR: begin
        if (bus.mem_ready) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      EXEC:     w_next = R_WB;
      R_WB, BRANCH, JUMP: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      ILLEGAL:  w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH;
      r_ctrl        <= decode(FETCH);
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next);
      if (w_retire) r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign w_fetch_done = (r_state == FETCH) && bus.mem_ready;

  // Write strobes are masked by reset so a mid-instruction reset commits nothing.
  assign bus.pc_write      = ~reset & (r_ctrl.pc_write | w_fetch_done);
  assign bus.ir_write      = ~reset & w_fetch_done;
  assign bus.pc_write_cond = ~reset & r_ctrl.pc_write_cond;
  assign bus.reg_write     = ~reset & r_ctrl.reg_write;
  assign bus.mem_write     = ~reset & r_ctrl.mem_write;

  assign bus.iord        = r_ctrl.iord;
  assign bus.mem_read    = r_ctrl.mem_read;
  assign bus.reg_dst     = r_ctrl.reg_dst;
  assign bus.mem_to_reg  = r_ctrl.mem_to_reg;
  assign bus.alu_src_a   = r_ctrl.alu_src_a;
  assign bus.alu_src_b   = r_ctrl.alu_src_b;
  assign bus.alu_op      = r_ctrl.alu_op;
  assign bus.pc_source   = r_ctrl.pc_source;
  assign bus.illegal_op  = r_ctrl.illegal_op;
  assign bus.state       = r_state;
  assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each scenario task drives the bus and
// compares state/strobes against hand-derived cycle tables.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    #1;
    checks++;
    if (bus.ir_write !== 1'b0) begin
      failures++; $display("FAIL reset_ir_write_pre got=%0h exp=0", bus.ir_write);
    end
    step();
    checks++;
    if (bus.state !== 4'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", bus.state);
    end
    checks++;
    if (bus.instr_count !== 16'h0000) begin
      failures++; $display("FAIL reset_count got=%0h exp=0", bus.instr_count);
    end
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++; $display("FAIL reset_illegal got=%0h exp=0", bus.illegal_op);
    end
    checks++;
    if ({bus.ir_write, bus.pc_write} !== 2'b00) begin
      failures++; $display("FAIL reset_fetch_strobes got=%0b exp=00", {bus.ir_write, bus.pc_write});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.mem_read, bus.iord, bus.ir_write, bus.pc_write} !== 8'b0000_1011) begin
      failures++;
      $display("FAIL post_reset_fetch got=%0b exp=00001011",
               {bus.state, bus.mem_read, bus.iord, bus.ir_write, bus.pc_write});
    end
    checks++;
    if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source} !== 7'b0_01_00_00) begin
      failures++;
      $display("FAIL fetch_alu got=%0b exp=0010000",
               {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source});
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
    do_reset();
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.state !== exp_st[i]) begin
        failures++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, bus.state, exp_st[i]);
      end
      checks++;
      if (bus.reg_write !== (exp_st[i] == 4'd7)) begin
        failures++; $display("FAIL rtype_reg_write[%0d] got=%0h exp=%0h", i, bus.reg_write, exp_st[i] == 4'd7);
      end
      if (exp_st[i] == 4'd7) begin
        checks++;
        if ({bus.reg_dst, bus.mem_to_reg} !== 2'b10) begin
          failures++; $display("FAIL rtype_wb_sel got=%0b exp=10", {bus.reg_dst, bus.mem_to_reg});
        end
      end
      if (exp_st[i] == 4'd6) begin
        checks++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== 5'b1_00_10) begin
          failures++; $display("FAIL rtype_exec_alu got=%0b exp=10010", {bus.alu_src_a, bus.alu_src_b, bus.alu_op});
        end
      end
      step();
    end
    #1;
    checks++;
    if ({bus.state, bus.instr_count} !== {4'd0, 16'd1}) begin
      failures++; $display("FAIL rtype_end got=%0d/%0d exp=0/1", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st [7];
    logic       mr     [7];
    int         rd_cycles;
    exp_st    = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    mr        = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rd_cycles = 0;
    do_reset();
    bus.opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #1;
      checks++;
      if (bus.state !== exp_st[i]) begin
        failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state, exp_st[i]);
      end
      checks++;
      if ((bus.mem_read & bus.mem_write) !== 1'b0) begin
        failures++; $display("FAIL lw_rd_wr_excl[%0d] got=%0h exp=0", i, bus.mem_read & bus.mem_write);
      end
      if (exp_st[i] == 4'd3) begin
        rd_cycles++;
        checks++;
        if ({bus.mem_read, bus.iord, bus.reg_write} !== 3'b110) begin
          failures++; $display("FAIL lw_memrd_strobes[%0d] got=%0b exp=110", i, {bus.mem_read, bus.iord, bus.reg_write});
        end
      end
      if (exp_st[i] == 4'd4) begin
        checks++;
        if ({bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== 3'b110) begin
          failures++; $display("FAIL lw_wb got=%0b exp=110", {bus.reg_write, bus.mem_to_reg, bus.reg_dst});
        end
      end
      step();
    end
    #1;
    checks++;
    if (rd_cycles !== 3) begin
      failures++; $display("FAIL lw_memrd_cycles got=%0d exp=3", rd_cycles);
    end
    checks++;
    if ({bus.state, bus.instr_count} !== {4'd0, 16'd1}) begin
      failures++; $display("FAIL lw_end got=%0d/%0d exp=0/1", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [10];
    logic [5:0] ops    [10];
    int         cond_hits;
    exp_st    = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
    ops       = '{6'b101011, 6'b101011, 6'b101011, 6'b101011,
                  6'b000100, 6'b000100, 6'b000100,
                  6'b000010, 6'b000010, 6'b000010};
    cond_hits = 0;
    do_reset();
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.opcode = ops[i];
      #1;
      checks++;
      if (bus.state !== exp_st[i]) begin
        failures++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, bus.state, exp_st[i]);
      end
      if (bus.pc_write_cond === 1'b1) cond_hits++;
      if (exp_st[i] == 4'd5) begin
        checks++;
        if ({bus.mem_write, bus.iord, bus.mem_read} !== 3'b110) begin
          failures++; $display("FAIL sw_strobes got=%0b exp=110", {bus.mem_write, bus.iord, bus.mem_read});
        end
      end
      if (exp_st[i] == 4'd8) begin
        checks++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source} !== 7'b1_00_01_01) begin
          failures++;
          $display("FAIL beq_ctrl got=%0b exp=1000101", {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source});
        end
      end
      if (exp_st[i] == 4'd9) begin
        checks++;
        if ({bus.pc_write, bus.pc_source} !== 3'b110) begin
          failures++; $display("FAIL j_ctrl got=%0b exp=110", {bus.pc_write, bus.pc_source});
        end
      end
      step();
    end
    #1;
    bus.zero = 1'b0;
    checks++;
    if (cond_hits !== 1) begin
      failures++; $display("FAIL b2b_pc_write_cond_count got=%0d exp=1", cond_hits);
    end
    checks++;
    if ({bus.state, bus.instr_count} !== {4'd0, 16'd3}) begin
      failures++; $display("FAIL b2b_end got=%0d/%0d exp=0/3", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] exp_st [4];
    int         ill_hits;
    exp_st   = '{4'd0, 4'd1, 4'd10, 4'd0};
    ill_hits = 0;
    do_reset();
    bus.opcode    = 6'b111111;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 0 || i == 2);
      #1;
      checks++;
      if (bus.state !== exp_st[i]) begin
        failures++; $display("FAIL illegal_state[%0d] got=%0d exp=%0d", i, bus.state, exp_st[i]);
      end
      if (bus.illegal_op === 1'b1) ill_hits++;
      if (i < 3) step();
    end
    checks++;
    if (ill_hits !== 1) begin
      failures++; $display("FAIL illegal_pulse_width got=%0d exp=1", ill_hits);
    end
    checks++;
    if (bus.instr_count !== 16'd0) begin
      failures++; $display("FAIL illegal_count got=%0d exp=0", bus.instr_count);
    end
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    bus.opcode    = 6'b101011;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    step();
    step();
    #1;
    checks++;
    if ({bus.state, bus.mem_write} !== 5'b0101_1) begin
      failures++; $display("FAIL midsw_wait got=%0d/%0h exp=5/1", bus.state, bus.mem_write);
    end
    step();
    #1;
    checks++;
    if ({bus.state, bus.mem_write} !== 5'b0101_1) begin
      failures++; $display("FAIL midsw_hold got=%0d/%0h exp=5/1", bus.state, bus.mem_write);
    end
    step();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.mem_write, bus.reg_write, bus.pc_write, bus.pc_write_cond, bus.ir_write} !== 5'b00000) begin
      failures++;
      $display("FAIL midsw_strobes_in_reset got=%0b exp=00000",
               {bus.mem_write, bus.reg_write, bus.pc_write, bus.pc_write_cond, bus.ir_write});
    end
    step();
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.instr_count, bus.mem_read} !== {4'd0, 16'd0, 1'b1}) begin
      failures++;
      $display("FAIL midsw_after got=%0d/%0d/%0h exp=0/0/1", bus.state, bus.instr_count, bus.mem_read);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (4 * 65534) step();
    checks++;
    if ({bus.state, bus.instr_count} !== {4'd0, 16'hFFFE}) begin
      failures++; $display("FAIL wrap_preload got=%0d/%0h exp=0/fffe", bus.state, bus.instr_count);
    end
    repeat (4) step();
    checks++;
    if (bus.instr_count !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_ffff got=%0h exp=ffff", bus.instr_count);
    end
    repeat (4) step();
    checks++;
    if ({bus.state, bus.instr_count} !== {4'd0, 16'h0000}) begin
      failures++; $display("FAIL wrap_zero got=%0d/%0h exp=0/0000", bus.state, bus.instr_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_reset_mid_sw();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 The port list SHALL be as follows:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (AND done in datapath)
- iord  out  1  memory address select: 0=PC, 1=ALU result register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register select: 0=rt, 1=rd
- mem_to_reg  out  1  write data select: 0=ALU result register, 1=memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=register B, 01=const 4, 10=sign-extend, 11=sign-extend<<2
- alu_op  out  2  00=add, 01=subtract, 10=use funct field
- pc_source  out  2  00=ALU out, 01=ALU result register, 10=jump target
- state  out  4  current state code
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instr_count  out  16  number of retired instructions

Function
REQ-003 The state codes SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ILLEGAL=10.
REQ-004 Any output not listed for a state SHALL be 0 in that state.
REQ-005 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_source=00.
REQ-006 In FETCH, ir_write and pc_write SHALL equal mem_ready; these are the only Mealy outputs.
REQ-007 FETCH SHALL go to DECODE when mem_ready=1, and otherwise stay in FETCH.
REQ-008 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00.
REQ-009 From DECODE, the next state SHALL be chosen by opcode:
- 000000 -> EXEC
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- any other opcode -> ILLEGAL
REQ-010 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00.
REQ-011 From MEM_ADDR, opcode 100011 SHALL go to MEM_RD and opcode 101011 SHALL go to MEM_WR.
REQ-012 MEM_RD SHALL drive mem_read=1 and iord=1, hold until mem_ready=1, then go to MEM_WB.
REQ-013 MEM_WB SHALL drive reg_dst=0, mem_to_reg=1 and reg_write=1, then go to FETCH.
REQ-014 MEM_WR SHALL drive mem_write=1 and iord=1, hold until mem_ready=1, then go to FETCH.
REQ-015 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to R_WB.
REQ-016 R_WB SHALL drive reg_dst=1, mem_to_reg=0 and reg_write=1, then go to FETCH.
REQ-017 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_source=01, then go to FETCH; zero is ignored by the FSM.
REQ-018 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-019 ILLEGAL SHALL pulse illegal_op=1 for exactly one cycle and then go to FETCH; the instruction SHALL NOT retire.
REQ-020 instr_count SHALL increment by 1 on each clock edge that leaves MEM_WB, MEM_WR (with mem_ready=1), R_WB, BRANCH or JUMP.
REQ-021 instr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-022 mem_read and mem_write SHALL never both be 1 in the same cycle.
REQ-023 While the FSM waits for mem_ready, all strobes SHALL hold stable; mem_ready toggling in a state that does not wait on it SHALL have no effect.
REQ-024 State latency SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, with zero wait states.
REQ-025 Each wait cycle in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle.

Reset
REQ-026 When reset=1 at a rising edge: state SHALL become FETCH, instr_count SHALL become 0 and illegal_op SHALL become 0.
REQ-027 During any cycle with reset=1, all write strobes (pc_write, pc_write_cond, ir_write, reg_write, mem_write) SHALL be forced to 0, whatever the state or mem_ready.
REQ-028 Reset asserted mid-instruction (for example in MEM_WR while waiting) SHALL abandon the instruction with no memory or register write, and SHALL NOT increment instr_count.
REQ-029 The first cycle after reset deasserts SHALL be FETCH with mem_read=1.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- R-type, mem_ready=1 constantly: state sequence SHALL be 0,1,6,7,0; reg_write=1 only in state 7 with reg_dst=1; instr_count goes 0->1.
- lw with mem_ready low for 2 cycles in MEM_RD: state 3 SHALL hold for 3 cycles with mem_read=1 and iord=1; total 7 cycles; reg_write with mem_to_reg=1 in state 4.
- sw, then beq, then j back-to-back with mem_ready=1: 4+3+3 cycles; pc_write_cond=1 exactly once; pc_write=1 in JUMP with pc_source=10; instr_count=3.
- opcode 111111: sequence SHALL be 0,1,10,0; illegal_op high for exactly 1 cycle; instr_count unchanged.
- Reset asserted in MEM_WR with mem_ready=0, then mem_ready=1 in the same cycle: no mem_write while reset=1; next state FETCH; instr_count=0.
- Preload instr_count to 0xFFFE by retiring 65534 R-type instructions, then retire 2 more: instr_count SHALL read 0x0000.
